if_id_skid_reg: RTL and testbench

Parametrised IF→ID pipeline boundary register for the five-stage CPU. It carries the instruction word, its PC and the branch-prediction bit. Unlike the plain IF/ID latch, it adds valid/ready back-pressure through a two-entry skid buffer, a synchronous flush that drops all in-flight beats, and a saturating stall-cycle counter. It is the next-generation stage register, reusable at any inter-stage boundary by changing widths.

---
 rtl/if_id_skid_reg.sv | 130 +++++++++++++
 tb/tb_if_id_skid_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with a two-entry skid buffer, flush and stall counter.
// The outputs, in_ready and out_valid all come straight from flops.
module if_id_skid_reg #(
   parameter int unsigned          INSTR_W  = 32,
   parameter int unsigned          ADDR_W   = 32,
   parameter logic [INSTR_W-1:0]   NOP_WORD = '0,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic               bp_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               bp_out,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
      logic               bp;
   } beat_t;

   // Bit 0 is the main valid and bit 1 is the skid valid.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b11
   } state_t;

   localparam beat_t NOP_BEAT = '{
      instr: NOP_WORD,
      pc:    '0,
      bp:    1'b0
   };

   state_t           state_q, state_d;
   beat_t            main_q, main_d;
   beat_t            skid_q, skid_d;
   beat_t            in_beat;
   logic [CNT_W-1:0] cnt_q;
   logic             in_fire;
   logic             out_fire;

   assign in_beat  = '{instr: instr_in, pc: pc_in, bp: bp_in};
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = NOP_BEAT;
         skid_d  = NOP_BEAT;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = ONE;
                  main_d  = in_beat;
               end
            end
            ONE: begin
               unique case (1'b1)
                  out_fire && in_fire: main_d = in_beat;
                  out_fire && !in_fire: begin
                     state_d = EMPTY;
                     main_d  = NOP_BEAT;
                  end
                  !out_fire && in_fire: begin
                     state_d = TWO;
                     skid_d  = in_beat;
                  end
                  default: ;
               endcase
            end
            TWO: begin
               if (out_fire) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = NOP_BEAT;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = NOP_BEAT;
               skid_d  = NOP_BEAT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= NOP_BEAT;
         skid_q  <= NOP_BEAT;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Saturating; counts the flush cycle too since it looks at current state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (out_valid && !out_ready && cnt_q != '1) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_valid = state_q[0];
   assign in_ready  = !state_q[1];
   assign instr_out = main_q.instr;
   assign pc_out    = main_q.pc;
   assign bp_out    = main_q.bp;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg with a beat scoreboard.
// CNT_W is 4 so the counter saturates within a short run.
module tb_if_id_skid_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic        bp_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        bp_out;
   logic [3:0]  stall_cnt;

   typedef struct {
      logic [31:0] i;
      logic [31:0] p;
      logic        b;
   } bt_t;

   bt_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  exp_cnt = 0;

   if_id_skid_reg #(
      .INSTR_W (32),
      .ADDR_W  (32),
      .NOP_WORD(32'h0),
      .CNT_W   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .instr_in (instr_in),
      .pc_in    (pc_in),
      .bp_in    (bp_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .instr_out(instr_out),
      .pc_out   (pc_out),
      .bp_out   (bp_out),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard bookkeeping before the edge, invariants after it.
   task automatic cyc();
      bt_t e;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_out", {63'b0, out_valid}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_instr", {32'b0, instr_out}, {32'b0, e.i});
            chk("sb_pc", {32'b0, pc_out}, {32'b0, e.p});
            chk("sb_bp", {63'b0, bp_out}, {63'b0, e.b});
         end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{instr_in, pc_in, bp_in});
      if (out_valid && !out_ready && exp_cnt != 15) exp_cnt++;
      @(posedge clk);
      #1;
      chk("out_valid", {63'b0, out_valid}, {63'b0, sb.size() != 0});
      chk("in_ready", {63'b0, in_ready}, {63'b0, sb.size() < 2});
      chk("stall_cnt", {60'b0, stall_cnt}, 64'(exp_cnt));
      if (!out_valid) begin
         chk("nop_instr", {32'b0, instr_out}, 64'd0);
         chk("nop_pc", {32'b0, pc_out}, 64'd0);
         chk("nop_bp", {63'b0, bp_out}, 64'd0);
      end
   endtask

   task automatic offer(input logic [31:0] i, input logic [31:0] p,
                        input logic b);
      in_valid = 1'b1;
      instr_in = i;
      pc_in    = p;
      bp_in    = b;
      cyc();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      cyc();
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      instr_in  = '0;
      pc_in     = '0;
      bp_in     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst_instr", {32'b0, instr_out}, 64'd0);
      chk("rst_cnt", {60'b0, stall_cnt}, 64'd0);
      rst = 1'b0;

      // Streaming at full rate.
      out_ready = 1'b1;
      offer(32'h11, 32'h0, 1'b0);
      chk("str_first", {32'b0, instr_out}, 64'h11);
      offer(32'h22, 32'h4, 1'b0);
      chk("str_second", {32'b0, instr_out}, 64'h22);
      offer(32'h33, 32'h8, 1'b0);
      chk("str_third_pc", {32'b0, pc_out}, 64'h8);
      idle();
      idle();

      // Back-pressure into the skid entry.
      offer(32'hA1, 32'h100, 1'b0);
      out_ready = 1'b0;
      offer(32'hA2, 32'h104, 1'b0);
      chk("bp_skid_rdy", {63'b0, in_ready}, 64'd0);
      offer(32'hA3, 32'h108, 1'b0);
      offer(32'hA3, 32'h108, 1'b0);
      chk("bp_stall3", {60'b0, stall_cnt}, 64'd3);
      chk("bp_hold_a1", {32'b0, instr_out}, 64'hA1);
      out_ready = 1'b1;
      idle();
      chk("bp_drain_a2", {32'b0, instr_out}, 64'hA2);
      chk("bp_rdy_back", {63'b0, in_ready}, 64'd1);
      idle();

      // Flush while in TWO discards the offered beat.
      offer(32'hB1, 32'h200, 1'b0);
      out_ready = 1'b0;
      offer(32'hB2, 32'h204, 1'b1);
      flush = 1'b1;
      offer(32'hB3, 32'h208, 1'b1);
      flush = 1'b0;
      chk("fl_valid", {63'b0, out_valid}, 64'd0);
      chk("fl_instr", {32'b0, instr_out}, 64'd0);
      chk("fl_pc", {32'b0, pc_out}, 64'd0);
      chk("fl_bp", {63'b0, bp_out}, 64'd0);
      chk("fl_rdy", {63'b0, in_ready}, 64'd1);
      out_ready = 1'b1;
      idle();
      idle();

      // Predict bit through the skid path, then cleared by flush.
      offer(32'hC1, 32'h300, 1'b0);
      out_ready = 1'b0;
      offer(32'hC2, 32'h304, 1'b1);
      idle();
      out_ready = 1'b1;
      idle();
      chk("bpb_instr", {32'b0, instr_out}, 64'hC2);
      chk("bpb_bit", {63'b0, bp_out}, 64'd1);
      out_ready = 1'b0;
      offer(32'hC3, 32'h308, 1'b1);
      chk("bpb_c2_held", {63'b0, bp_out}, 64'd1);
      flush = 1'b1;
      idle();
      flush = 1'b0;
      chk("bpb_flush", {63'b0, bp_out}, 64'd0);

      // Saturation of the 4-bit counter.
      offer(32'hD1, 32'h400, 1'b0);
      for (int k = 0; k < 20; k++) idle();
      chk("sat_15", {60'b0, stall_cnt}, 64'd15);
      idle();
      chk("sat_hold", {60'b0, stall_cnt}, 64'd15);

      // Asynchronous reset from TWO.
      offer(32'hE1, 32'h500, 1'b1);
      chk("pre_rst_two", {63'b0, in_ready}, 64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", {63'b0, out_valid}, 64'd0);
      chk("arst_instr", {32'b0, instr_out}, 64'd0);
      chk("arst_rdy", {63'b0, in_ready}, 64'd1);
      chk("arst_cnt", {60'b0, stall_cnt}, 64'd0);
      sb.delete();
      exp_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      offer(32'hF1, 32'h600, 1'b0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
